y_sram_responder: RTL and testbench

//  Memory-side end of the Y SRAM bus: consumes the arbitrated 2R/1W address, write-enable and data bus, and returns registered read data.

---
 rtl/y_sram_responder.sv | 193 +++++++++++++++++++
 tb/tb_y_sram_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/y_sram_responder.sv
// y_sram_responder: memory-side end of the Y SRAM bus (2 read / 1 write), registered reads, cleared after reset.
// Optional per-word even parity is enabled by defining YSRAM_PARITY_EN.
module y_sram_responder #(
   parameter int                ADDR_W    = 11,
   parameter int                DATA_W    = 256,
   parameter int                DEPTH     = 2047,
   parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}},
   parameter bit                BYPASS    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] in_yReadAddress1,
   input  logic [ADDR_W-1:0] in_yReadAddress2,
   input  logic              in_yWriteEnable,
   input  logic [ADDR_W-1:0] in_yWriteAddress,
   input  logic [DATA_W-1:0] in_writeData,
   output logic [DATA_W-1:0] op_readData1,
   output logic [DATA_W-1:0] op_readData2,
   output logic              op_readValid1,
   output logic              op_readValid2,
   output logic              op_ready,
   output logic [15:0]       op_collisionCount,
   output logic              op_rangeErr,
   output logic              op_parityErr
);
   localparam int                IDX_W    = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
   logic              rv1_q, rv1_d, rv2_q, rv2_d;
   logic [15:0]       cc_q, cc_d;
   logic              rerr_q, rerr_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we_s;
   logic [IDX_W-1:0]  mem_wa_s;
   logic [DATA_W-1:0] mem_wd_s;
   logic [IDX_W-1:0]  ridx1_s, ridx2_s;
   logic [DATA_W-1:0] mem_rd1_s, mem_rd2_s;
   logic              in_rng1_s, in_rng2_s, wr_ok_s, hit1_s, hit2_s;

   // Out-of-range addresses alias into the array but are never marked valid or written.
   assign ridx1_s   = in_yReadAddress1[IDX_W-1:0];
   assign ridx2_s   = in_yReadAddress2[IDX_W-1:0];
   assign mem_rd1_s = mem[ridx1_s];
   assign mem_rd2_s = mem[ridx2_s];
   assign in_rng1_s = (in_yReadAddress1 < DEPTH_A);
   assign in_rng2_s = (in_yReadAddress2 < DEPTH_A);
   assign wr_ok_s   = in_yWriteEnable && (in_yWriteAddress < DEPTH_A);
   assign hit1_s    = wr_ok_s && (in_yWriteAddress == in_yReadAddress1);
   assign hit2_s    = wr_ok_s && (in_yWriteAddress == in_yReadAddress2);

   // Next state, storage write port and next values of the registered outputs.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      mem_we_s = 1'b0;
      mem_wa_s = ptr_q;
      mem_wd_s = '0;
      rd1_d    = '0;
      rd2_d    = '0;
      rv1_d    = 1'b0;
      rv2_d    = 1'b0;
      cc_d     = cc_q;
      rerr_d   = rerr_q;
      case (state_q)
         ST_INIT: begin
            mem_we_s = 1'b1;
            if (ptr_q == LAST_IDX) begin
               state_d = ST_READY;
            end else begin
               ptr_d = ptr_q + IDX_W'(1);
            end
         end
         ST_READY: begin
            mem_we_s = wr_ok_s;
            mem_wa_s = in_yWriteAddress[IDX_W-1:0];
            mem_wd_s = in_writeData;
            rv1_d    = in_rng1_s;
            rv2_d    = in_rng2_s;
            if (in_rng1_s) begin
               rd1_d = (BYPASS && hit1_s) ? in_writeData : mem_rd1_s;
            end else begin
               rd1_d = '0;
            end
            if (in_rng2_s) begin
               rd2_d = (BYPASS && hit2_s) ? in_writeData : mem_rd2_s;
            end else begin
               rd2_d = '0;
            end
            // One increment per hazard cycle, however many ports hit.
            if ((hit1_s || hit2_s) && (cc_q != 16'hffff)) begin
               cc_d = cc_q + 16'd1;
            end else begin
               cc_d = cc_q;
            end
            if (in_yWriteEnable && !wr_ok_s && (in_yWriteAddress != IDLE_ADDR)) begin
               rerr_d = 1'b1;
            end else begin
               rerr_d = rerr_q;
            end
         end
         default: begin
            state_d = ST_INIT;
            ptr_d   = '0;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         rv1_q   <= 1'b0;
         rv2_q   <= 1'b0;
         cc_q    <= 16'd0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         rv1_q   <= rv1_d;
         rv2_q   <= rv2_d;
         cc_q    <= cc_d;
         rerr_q  <= rerr_d;
      end
   end

   // Word storage; content is don't-care until INIT has swept it.
   always_ff @(posedge clk) begin
      if (reset && mem_we_s) begin
         mem[mem_wa_s] <= mem_wd_s;
      end
   end

`ifdef YSRAM_PARITY_EN
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   logic par_mem [DEPTH];
   logic perr_q, perr_d;

   // Parity plane written alongside the data storage.
   always_ff @(posedge clk) begin
      if (reset && mem_we_s) begin
         par_mem[mem_wa_s] <= even_parity(mem_wd_s);
      end
   end

   // Bypassed words never came from storage, so they are excluded from the check.
   always_comb begin
      perr_d = perr_q;
      if (state_q == ST_READY) begin
         perr_d = perr_q
                | (in_rng1_s && !(BYPASS && hit1_s) && (par_mem[ridx1_s] != even_parity(mem_rd1_s)))
                | (in_rng2_s && !(BYPASS && hit2_s) && (par_mem[ridx2_s] != even_parity(mem_rd2_s)));
      end else begin
         perr_d = perr_q;
      end
   end

   // Sticky parity error flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign op_parityErr = perr_q;
`else
   assign op_parityErr = 1'b0;
`endif

   assign op_readData1      = rd1_q;
   assign op_readData2      = rd2_q;
   assign op_readValid1     = rv1_q;
   assign op_readValid2     = rv2_q;
   assign op_ready          = (state_q == ST_READY);
   assign op_collisionCount = cc_q;
   assign op_rangeErr       = rerr_q;
endmodule

// File: tb/tb_y_sram_responder.sv
// Scoreboard bench for y_sram_responder: stimulus pushes expected responses, a monitor pops and compares.
module tb_y_sram_responder;
   localparam int          DEPTH  = 1024;
   localparam bit          BYPASS = 1'b1;
   localparam logic [10:0] IDLE   = 11'h7ff;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [10:0]  ra1 = IDLE, ra2 = IDLE, waddr = IDLE;
   logic         wen = 1'b0;
   logic [255:0] wdata = '0;
   logic [255:0] rdata1, rdata2;
   logic         rvalid1, rvalid2, ready, range_err, parity_err;
   logic [15:0]  coll_cnt;

   y_sram_responder #(.ADDR_W(11), .DATA_W(256), .DEPTH(DEPTH), .BYPASS(BYPASS)) dut (
      .clk(clk), .reset(reset),
      .in_yReadAddress1(ra1), .in_yReadAddress2(ra2),
      .in_yWriteEnable(wen), .in_yWriteAddress(waddr), .in_writeData(wdata),
      .op_readData1(rdata1), .op_readData2(rdata2),
      .op_readValid1(rvalid1), .op_readValid2(rvalid2),
      .op_ready(ready), .op_collisionCount(coll_cnt),
      .op_rangeErr(range_err), .op_parityErr(parity_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           due;
      logic [255:0] d1, d2;
      logic         v1, v2, rdy, rerr;
      logic [15:0]  cc;
      string        tag;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [255:0] mdl [int];
   logic [15:0]  m_cc = 16'd0;
   logic         m_rerr = 1'b0;
   logic         m_ready = 1'b0;

   function automatic void cmp(string name, logic [255:0] act, logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [255:0] rd_mdl(logic [10:0] a);
      return mdl.exists(int'(a)) ? mdl[int'(a)] : 256'd0;
   endfunction

   // One bus cycle: drive, predict the response due one cycle later, update the model.
   task automatic cyc_op(input logic [10:0] r1, input logic [10:0] r2, input logic we,
                         input logic [10:0] wa, input logic [255:0] wd, input bit chk, input string tag);
      exp_t e;
      bit   wok, h1, h2;
      @(negedge clk);
      ra1 = r1; ra2 = r2; wen = we; waddr = wa; wdata = wd;
      e.due = cyc + 1; e.tag = tag; e.rdy = m_ready;
      e.d1 = '0; e.d2 = '0; e.v1 = 1'b0; e.v2 = 1'b0;
      if (m_ready) begin
         wok = we && (int'(wa) < DEPTH);
         h1  = wok && (wa == r1);
         h2  = wok && (wa == r2);
         if (int'(r1) < DEPTH) begin e.v1 = 1'b1; e.d1 = (BYPASS && h1) ? wd : rd_mdl(r1); end
         if (int'(r2) < DEPTH) begin e.v2 = 1'b1; e.d2 = (BYPASS && h2) ? wd : rd_mdl(r2); end
         if ((h1 || h2) && m_cc != 16'hffff) m_cc = m_cc + 16'd1;
         if (we && int'(wa) >= DEPTH && wa != IDLE) m_rerr = 1'b1;
         if (wok) mdl[int'(wa)] = wd;
      end
      e.cc = m_cc; e.rerr = m_rerr;
      if (chk) sb.push_back(e);
   endtask

   // Hold reset low for n cycles, then release with junk traffic that INIT must ignore.
   task automatic do_reset(input int n, input string tag);
      exp_t e;
      @(negedge clk);
      reset = 1'b0; ra1 = IDLE; ra2 = IDLE; wen = 1'b0; waddr = IDLE; wdata = '0;
      m_cc = 16'd0; m_rerr = 1'b0; m_ready = 1'b0; mdl.delete();
      e.due = cyc + 1; e.tag = tag; e.rdy = 1'b0; e.d1 = '0; e.d2 = '0;
      e.v1 = 1'b0; e.v2 = 1'b0; e.cc = 16'd0; e.rerr = 1'b0;
      sb.push_back(e);
      repeat (n - 1) @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      ra1 = 11'h005; ra2 = 11'h000; wen = 1'b1; waddr = 11'h005; wdata = {32{8'h5a}};
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      bit bad = 1'b0;
      do begin
         @(posedge clk); #2;
         n++;
         if (!ready) bad |= rvalid1 | rvalid2 | range_err | (coll_cnt != 16'd0) | (rdata1 != '0);
      end while (!ready && n < DEPTH + 20);
      ra1 = IDLE; ra2 = IDLE; wen = 1'b0; waddr = IDLE; wdata = '0;
      cmp({tag, " ready_latency"}, 256'(n), 256'(DEPTH));
      cmp({tag, " init_quiet"}, 256'(bad), 256'd0);
      m_ready = 1'b1;
   endtask

   // Monitor: compares every response whose cycle has come.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #2;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
               n_tests++; n_fail++;
               $display("FAIL %s stale: due %0d now %0d", e.tag, e.due, cyc);
            end else begin
               cmp({e.tag, ".d1"}, rdata1, e.d1);
               cmp({e.tag, ".v1"}, 256'(rvalid1), 256'(e.v1));
               cmp({e.tag, ".d2"}, rdata2, e.d2);
               cmp({e.tag, ".v2"}, 256'(rvalid2), 256'(e.v2));
               cmp({e.tag, ".rdy"}, 256'(ready), 256'(e.rdy));
               cmp({e.tag, ".cc"}, 256'(coll_cnt), 256'(e.cc));
               cmp({e.tag, ".rerr"}, 256'(range_err), 256'(e.rerr));
               cmp({e.tag, ".perr"}, 256'(parity_err), 256'd0);
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] pat_a5, pat_dead, pat_x;
      pat_a5   = {32{8'ha5}};
      pat_dead = {16{16'hdead}};
      pat_x    = {8{32'h1234_5678}};

      do_reset(3, "rst1");
      wait_ready("init1");
      cyc_op(11'h000, 11'h3ff, 1'b0, IDLE, '0, 1'b1, "rd_bounds");
      cyc_op(11'h005, 11'h000, 1'b0, IDLE, '0, 1'b1, "init_wr_ignored");

      cyc_op(IDLE, IDLE, 1'b1, 11'h005, pat_a5, 1'b1, "wr5");
      cyc_op(11'h005, IDLE, 1'b0, IDLE, '0, 1'b1, "rd5_idle");

      cyc_op(11'h010, 11'h010, 1'b1, 11'h010, pat_dead, 1'b1, "bypass_both");
      cyc_op(11'h010, 11'h010, 1'b0, IDLE, '0, 1'b1, "same_addr_no_coll");
      cyc_op(11'h005, 11'h011, 1'b1, 11'h011, pat_x, 1'b1, "bypass_p2");
      cyc_op(11'h3ff, 11'h010, 1'b1, 11'h3ff, ~pat_x, 1'b1, "bypass_last");
      cyc_op(11'h3ff, 11'h011, 1'b0, IDLE, '0, 1'b1, "rd_last");

      cyc_op(IDLE, IDLE, 1'b1, IDLE, pat_dead, 1'b1, "wr_idle_noop");
      cyc_op(11'h400, IDLE, 1'b1, 11'h400, pat_a5, 1'b1, "wr_range");
      cyc_op(11'h400, 11'h7fe, 1'b0, IDLE, '0, 1'b1, "rd_range");
      cyc_op(11'h000, 11'h005, 1'b1, 11'h000, pat_x, 1'b1, "rerr_sticky");

      cyc_op(11'h000, 11'h000, 1'b1, 11'h000, pat_a5, 1'b1, "pre_reset");
      do_reset(1, "rst_traffic");
      repeat (100) @(negedge clk);
      do_reset(2, "rst_init");
      wait_ready("init2");
      cyc_op(11'h005, 11'h010, 1'b0, IDLE, '0, 1'b1, "cleared");

      for (int i = 0; i < 65533; i++) begin
         cyc_op(11'h020, IDLE, 1'b1, 11'h020, 256'(i), 1'b0, "bulk");
      end
      cyc_op(11'h020, IDLE, 1'b1, 11'h020, pat_a5, 1'b1, "cc_fffe");
      cyc_op(IDLE, 11'h020, 1'b1, 11'h020, pat_x, 1'b1, "cc_ffff");
      for (int i = 0; i < 5; i++) begin
         cyc_op(11'h020, 11'h020, 1'b1, 11'h020, 256'(i), 1'b0, "bulk2");
      end
      cyc_op(11'h020, 11'h021, 1'b1, 11'h020, pat_dead, 1'b1, "cc_sat");

      repeat (3) @(negedge clk);
      cmp("sb_drained", 256'(sb.size()), 256'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
